// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - circular pipeline-register trace buffer with arm/trigger/post capture and readout
// Optional PIPE_TRACE_FILTER_EN: record only cycles where any ch_valid bit is set.
module pipe_trace_buffer #(
  parameter int CH_WIDTH = 32,
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 16,
  parameter int CYCLE_W  = 32
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [NUM_CH*CH_WIDTH-1:0]              ch_data,
  input  logic [NUM_CH-1:0]                       ch_valid,
  input  logic                                    arm,
  input  logic                                    trig,
  input  logic [$clog2(DEPTH):0]                  post_trig,
  input  logic [CYCLE_W-1:0]                      stop_cycle,
  input  logic                                    rd_en,
  output logic [CYCLE_W+NUM_CH+NUM_CH*CH_WIDTH-1:0] rd_data,
  output logic                                    rd_valid,
  output logic                                    rd_empty,
  output logic [CYCLE_W-1:0]                      cycle_count,
  output logic [1:0]                              state,
  output logic                                    halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = CYCLE_W + NUM_CH + NUM_CH * CH_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  state_t         cur, nxt;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [PW-1:0]  count, post_cnt, post_load;
  logic           sample_ok, halt_hit, halt_now;
  logic           do_write, do_read, load_post;

`ifdef PIPE_TRACE_FILTER_EN
  assign sample_ok = |ch_valid;
`else
  assign sample_ok = 1'b1;
`endif

  // halt_hit fires once; afterwards the sticky flag keeps the counter frozen
  assign halt_hit  = (stop_cycle != '0) && (cycle_count == stop_cycle) && !halt;
  assign halt_now  = halt | halt_hit;
  assign post_load = (post_trig > PW'(DEPTH)) ? PW'(DEPTH) : post_trig;
  assign rd_empty  = (count == '0) || (cur != S_DONE);
  assign state     = cur;

  always_ff @(posedge CLK) begin
    if (RST) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    do_write  = 1'b0;
    do_read   = 1'b0;
    load_post = 1'b0;
    case (cur)
      S_IDLE: begin
        if (arm) nxt = S_ARMED;
      end
      S_ARMED: begin
        do_write = sample_ok;
        if (halt_now) begin
          nxt = S_DONE;
        end else if (trig) begin
          load_post = 1'b1;
          nxt       = (post_load == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        do_write = sample_ok;
        if (halt_now || post_cnt == '0 || (sample_ok && post_cnt == PW'(1)))
          nxt = S_DONE;
      end
      S_DONE: begin
        do_read = rd_en && (count != '0);
        if (count == '0 && !do_read) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr] <= {cycle_count, ch_valid, ch_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      post_cnt    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      cycle_count <= '0;
      halt        <= 1'b0;
    end else begin
      rd_valid <= do_read;
      if (!halt_now) cycle_count <= cycle_count + 1'b1;
      if (halt_hit)  halt <= 1'b1;
      if (cur == S_IDLE && arm) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end
      // a full buffer drops its oldest entry so readout stays oldest-first
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == PW'(DEPTH)) rd_ptr <= rd_ptr + 1'b1;
        else                     count  <= count + 1'b1;
      end
      if (do_read) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        count   <= count - 1'b1;
      end
      if (load_post)
        post_cnt <= post_load;
      else if (cur == S_POST && do_write && post_cnt != '0)
        post_cnt <= post_cnt - 1'b1;
    end
  end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable trace-capture block that replaces simulation-only monitoring of pipeline registers with an on-chip circular snapshot buffer.
- Samples NUM_CH channels (for example IF/ID, ID/EX, EX/MEM and MEM/WB buses) every cycle, tagged with a free-running cycle stamp.
- Supports arm/trigger/post-trigger capture, a programmable halt cycle, and an oldest-first readout port for the bench or a debug host.

Parameters:
- CH_WIDTH, 32, width of each channel data bus
- NUM_CH, 4, number of traced channels
- DEPTH, 16, number of snapshot entries; must be a power of 2, minimum 2
- CYCLE_W, 32, cycle counter and stamp width

Ports:
- CLK  input  1  clock; all logic on posedge
- RST  input  1  synchronous, active-high reset
- ch_data  input  NUM_CH*CH_WIDTH  channel buses; channel i occupies bits [i*CH_WIDTH +: CH_WIDTH]
- ch_valid  input  NUM_CH  per-channel valid mask
- arm  input  1  start pre-trigger capture (pulse)
- trig  input  1  trigger event (pulse)
- post_trig  input  $clog2(DEPTH)+1  entries to record after the trigger; values above DEPTH are treated as DEPTH
- stop_cycle  input  CYCLE_W  halt cycle; 0 disables halt
- rd_en  input  1  pop the oldest entry
- rd_data  output  CYCLE_W+NUM_CH+NUM_CH*CH_WIDTH  {stamp, ch_valid, ch_data}
- rd_valid  output  1  rd_data valid; a 1-cycle pulse
- rd_empty  output  1  no entries remain to read
- cycle_count  output  CYCLE_W  cycle counter
- state  output  2  current state; 0=IDLE, 1=ARMED, 2=POST, 3=DONE
- halt  output  1  sticky halt flag

Behaviour:
- Reset (RST=1 on a posedge):
  - state=IDLE; cycle_count=0; halt=0; rd_valid=0; rd_data=0; rd_empty=1.
  - Write pointer, read pointer, entry count and post counter all cleared.
  - Applies from any state, including mid-capture and mid-readout.
  - Buffer RAM contents are don't-care after reset.
- cycle_count:
  - Increments by 1 every cycle and wraps at 2^CYCLE_W.
  - Freezes while halt=1.
- halt:
  - Set on the cycle cycle_count==stop_cycle, when stop_cycle!=0.
  - Once set, stays set until RST.
- Sample write:
  - Entry = {cycle_count, ch_valid, ch_data}, written at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - count saturates at DEPTH; once full, the oldest entry is overwritten and rd_ptr advances with it.
- IDLE:
  - No writes; trig ignored.
  - arm -> ARMED. The buffer is cleared (count=0, pointers equal); the first sample is taken in the cycle after arm.
- ARMED:
  - Writes a sample every cycle (circular).
  - trig -> POST. The trigger-cycle sample is written and post_cnt is loaded with min(post_trig, DEPTH).
  - If that loaded value is 0, go -> DONE instead.
  - arm while ARMED is ignored.
- POST:
  - Writes a sample each cycle and decrements post_cnt.
  - When the write that brings post_cnt to 0 completes -> DONE.
  - trig and arm are ignored.
- DONE:
  - No writes.
  - rd_en with count>0: rd_data = entry at rd_ptr, rd_valid=1 on the next cycle, rd_ptr+1, count-1.
  - rd_en with count==0: no effect, rd_valid stays 0.
  - When count reaches 0 and no read is pending -> IDLE.
  - arm while in DONE is ignored.
- rd_empty = (count==0) || (state!=DONE).
- Halt while in ARMED or POST: the sample in the halt cycle is written, then -> DONE. Halt while in IDLE or DONE: no state change.
- Simultaneous events:
  - arm and trig together in IDLE: arm wins, trig is dropped.
  - trig and halt together in ARMED: go DONE; post-trigger capture is skipped.
- rd_data holds its last value between reads.

Optional Feature:
- Macro: PIPE_TRACE_FILTER_EN.
- Defined: in ARMED and POST, a sample is written only when |ch_valid. POST decrements only on cycles that actually write. Cycle stamps show the gaps between written samples.
- Undefined: a sample is written every cycle in ARMED and POST, regardless of ch_valid.

Test Plan:
All scenarios use DEPTH=4, NUM_CH=2, CH_WIDTH=8, CYCLE_W=16.
- Reset/idle: RST for 2 cycles, then idle for 10 cycles -> state=0, rd_empty=1, halt=0, cycle_count=10, no rd_valid.
- Wrap/overwrite: arm at cycle 5; ch_data = cycle low byte on both channels; trig at cycle 14; post_trig=1 -> DONE. Reading 4 entries gives stamps 12, 13, 14, 15 in order with rd_valid pulses; rd_empty=1 after the 4th read; state returns to IDLE.
- post_trig clamp: post_trig=7 (above DEPTH) -> exactly 4 post-trigger samples recorded; the trigger sample has been overwritten; the first read stamp is trig+1.
- Halt: stop_cycle=20, arm at 3, no trig -> halt=1 at cycle 20; cycle_count holds 20; state=DONE; stamps read 17, 18, 19, 20.
- Reset mid-readout: after 2 of 4 reads, assert RST -> state=0, rd_empty=1, cycle_count=0, halt=0; a fresh arm capture then works normally.
- Filter (PIPE_TRACE_FILTER_EN defined): ch_valid=2'b01 only on cycles 10, 12, 15, 18; arm at 8; trig at 12; post_trig=2 -> entries are stamps 10, 12, 15, 18, then DONE. Without the macro, the same stimulus yields stamps 11, 12, 13, 14.
